mips_exec_mem_unit: RTL and testbench

Single-cycle execute/memory slice of the 32-bit MIPS datapath: instruction decoder (controller), 32-bit ALU with operand-B select, and a 64-word data memory with write-back select. It sits between the register file and instruction memory and the register-file write port. It returns all control strobes, the ALU result and zero flag, the branch decision, and the register write-back data.

---
 rtl/mips_exec_mem_unit.sv | 137 +++++++++++++
 tb/tb_mips_exec_mem_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_exec_mem_unit.sv
// Single-cycle execute/memory slice: controller, 32-bit ALU with operand-B select,
// 64-word data memory with combinational read, and the register write-back select.
module mips_exec_mem_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    input  logic [31:0] extend32,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        ALUSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        branch,
    output logic [1:0]  ALUOperation,
    output logic [31:0] alu_out,
    output logic        Zero,
    output logic        branch_taken,
    output logic [31:0] WriteDataReg
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int DEPTH = 64;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] operand_b;
    logic [5:0]  mem_index;
    logic [31:0] mem_data;
    logic [31:0] mem_words [DEPTH];
    logic        unused_bits;

    assign opcode = instruction[31:26];
    assign funct  = instruction[5:0];

    // Controller: every strobe defaults low so unknown encodings become no-ops.
    always_comb begin
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        MemToReg     = 1'b0;
        ALUSrc       = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        branch       = 1'b0;
        ALUOperation = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_ADD || funct == FN_SUB ||
                    funct == FN_AND || funct == FN_OR) begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                    case (funct)
                        FN_SUB:  ALUOperation = ALU_SUB;
                        FN_AND:  ALUOperation = ALU_AND;
                        FN_OR:   ALUOperation = ALU_OR;
                        default: ALUOperation = ALU_ADD;
                    endcase
                end
            end
            OP_LW: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
                MemRead  = 1'b1;
                MemToReg = 1'b1;
            end
            OP_SW: begin
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            OP_BEQ: begin
                branch       = 1'b1;
                ALUOperation = ALU_SUB;
            end
            OP_ADDI: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign operand_b = ALUSrc ? extend32 : read_data2;

    always_comb begin
        alu_out = read_data1 + operand_b;
        case (ALUOperation)
            ALU_SUB: alu_out = read_data1 - operand_b;
            ALU_AND: alu_out = read_data1 & operand_b;
            ALU_OR:  alu_out = read_data1 | operand_b;
            default: alu_out = read_data1 + operand_b;
        endcase
    end

    assign Zero         = (alu_out == 32'd0);
    assign branch_taken = branch & Zero;

    // Byte-offset and upper address bits are dropped: addresses wrap every 256 bytes.
    assign mem_index = alu_out[7:2];

    // Each word is its own register so reset can clear the whole memory in one edge.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_word
            logic [31:0] word_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg <= 32'd0;
                end else if (MemWrite && (mem_index == 6'(gi))) begin
                    word_reg <= read_data2;
                end
            end
            assign mem_words[gi] = word_reg;
        end
    endgenerate

    assign mem_data     = mem_words[mem_index];
    assign WriteDataReg = MemToReg ? mem_data : alu_out;

    assign unused_bits = ^{instruction[25:6], alu_out[31:8], alu_out[1:0]};

endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Self-checking bench for mips_exec_mem_unit: directed scenarios plus a randomized
// instruction stream compared against an instruction-level reference model.
module tb_mips_exec_mem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction, read_data1, read_data2, extend32;
    logic        RegDst, RegWrite, MemToReg, ALUSrc, MemRead, MemWrite, branch;
    logic [1:0]  ALUOperation;
    logic [31:0] alu_out;
    logic        Zero, branch_taken;
    logic [31:0] WriteDataReg;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem_model [64];

    typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_LW, K_SW, K_BEQ, K_ADDI, K_BADR, K_BADOP} kind_t;

    mips_exec_mem_unit dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .read_data1(read_data1), .read_data2(read_data2), .extend32(extend32),
        .RegDst(RegDst), .RegWrite(RegWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc),
        .MemRead(MemRead), .MemWrite(MemWrite), .branch(branch),
        .ALUOperation(ALUOperation), .alu_out(alu_out), .Zero(Zero),
        .branch_taken(branch_taken), .WriteDataReg(WriteDataReg)
    );

    always #5 clk = ~clk;

    // Control word order: RegDst RegWrite MemToReg ALUSrc MemRead MemWrite branch ALUOp[1:0]
    function automatic logic [8:0] strobes_of(kind_t k);
        case (k)
            K_ADD:   return 9'b1100000_00;
            K_SUB:   return 9'b1100000_01;
            K_AND:   return 9'b1100000_10;
            K_OR:    return 9'b1100000_11;
            K_LW:    return 9'b0111100_00;
            K_SW:    return 9'b0001010_00;
            K_BEQ:   return 9'b0000001_01;
            K_ADDI:  return 9'b0101000_00;
            default: return 9'b0000000_00;
        endcase
    endfunction

    function automatic logic [31:0] make_instr(kind_t k);
        logic [5:0] op;
        logic [5:0] fn;
        logic [19:0] mid;
        mid = 20'($urandom);
        fn  = 6'($urandom);
        op  = 6'h00;
        case (k)
            K_ADD:  fn = 6'h20;
            K_SUB:  fn = 6'h22;
            K_AND:  fn = 6'h24;
            K_OR:   fn = 6'h25;
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2B;
            K_BEQ:  op = 6'h04;
            K_ADDI: op = 6'h08;
            K_BADR: while (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25) fn = 6'($urandom);
            default: begin
                op = 6'($urandom);
                while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08)
                    op = 6'($urandom);
            end
        endcase
        return {op, mid, fn};
    endfunction

    function automatic logic [31:0] result_of(kind_t k, logic [31:0] a, logic [31:0] b, logic [31:0] imm);
        case (k)
            K_SUB, K_BEQ:        return a - b;
            K_AND:               return a & b;
            K_OR:                return a | b;
            K_LW, K_SW, K_ADDI:  return a + imm;
            default:             return a + b;
        endcase
    endfunction

    function automatic logic [8:0] dut_strobes();
        return {RegDst, RegWrite, MemToReg, ALUSrc, MemRead, MemWrite, branch, ALUOperation};
    endfunction

    task automatic drive(kind_t k, logic [31:0] a, logic [31:0] b, logic [31:0] imm, logic r);
        @(negedge clk);
        instruction = make_instr(k);
        read_data1  = a;
        read_data2  = b;
        extend32    = imm;
        rst         = r;
        #1;
    endtask

    task automatic test_reset();
        drive(K_SW, 32'h0, 32'hCAFE0001, 32'h8, 1'b1);
        @(posedge clk);
        foreach (mem_model[i]) mem_model[i] = 32'd0;
        drive(K_LW, 32'h0, 32'h0, 32'h8, 1'b0);
        vectors++;
        if (dut_strobes() !== strobes_of(K_LW)) begin
            miscompares++;
            $display("FAIL reset_lw_strobes got=%b want=%b", dut_strobes(), strobes_of(K_LW));
        end
        vectors++;
        if (alu_out !== 32'd8) begin
            miscompares++;
            $display("FAIL reset_lw_addr got=%h want=%h", alu_out, 32'd8);
        end
        vectors++;
        if (WriteDataReg !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_lw_data got=%h want=%h", WriteDataReg, 32'd0);
        end
        $display("reset then lw @8: wb=%h", WriteDataReg);
    endtask

    task automatic test_store_load();
        drive(K_SW, 32'h10, 32'hDEADBEEF, 32'h4, 1'b0);
        @(posedge clk);
        mem_model[5] = 32'hDEADBEEF;
        drive(K_LW, 32'h10, 32'h0, 32'h4, 1'b0);
        vectors++;
        if (WriteDataReg !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL store_load got=%h want=%h", WriteDataReg, 32'hDEADBEEF);
        end
        drive(K_LW, 32'h100, 32'h0, 32'h14, 1'b0);
        vectors++;
        if (WriteDataReg !== 32'hDEADBEEF || alu_out !== 32'h114) begin
            miscompares++;
            $display("FAIL store_load_wrap got=%h addr=%h want=%h addr=114", WriteDataReg, alu_out, 32'hDEADBEEF);
        end
        $display("sw/lw round trip: wb=%h", WriteDataReg);
    endtask

    task automatic test_rtype();
        kind_t       ks   [4] = '{K_ADD, K_SUB, K_AND, K_OR};
        logic [31:0] want [4] = '{32'h0, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            drive(ks[i], 32'hFFFFFFFF, 32'h1, 32'h5A5A5A5A, 1'b0);
            vectors++;
            if (alu_out !== want[i] || Zero !== (want[i] == 0) || WriteDataReg !== want[i]) begin
                miscompares++;
                $display("FAIL rtype_%0d alu=%h zero=%b wb=%h want=%h", i, alu_out, Zero, WriteDataReg, want[i]);
            end
            vectors++;
            if (dut_strobes() !== strobes_of(ks[i])) begin
                miscompares++;
                $display("FAIL rtype_%0d_strobes got=%b want=%b", i, dut_strobes(), strobes_of(ks[i]));
            end
            $display("rtype %0d: alu=%h zero=%b", i, alu_out, Zero);
        end
    endtask

    task automatic test_beq();
        logic [31:0] bval [2]  = '{32'd5, 32'd6};
        logic        taken [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            drive(K_BEQ, 32'd5, bval[i], 32'd0, 1'b0);
            vectors++;
            if (branch_taken !== taken[i] || Zero !== taken[i] || dut_strobes() !== strobes_of(K_BEQ)) begin
                miscompares++;
                $display("FAIL beq_%0d taken=%b zero=%b strobes=%b want_taken=%b", i, branch_taken, Zero, dut_strobes(), taken[i]);
            end
            $display("beq 5 vs %0d: taken=%b", bval[i], branch_taken);
        end
    endtask

    task automatic test_addi_unknown();
        drive(K_ADDI, 32'd7, 32'h0, 32'hFFFFFFFE, 1'b0);
        vectors++;
        if (alu_out !== 32'd5 || WriteDataReg !== 32'd5 || dut_strobes() !== strobes_of(K_ADDI)) begin
            miscompares++;
            $display("FAIL addi alu=%h wb=%h strobes=%b want alu=5", alu_out, WriteDataReg, dut_strobes());
        end
        $display("addi 7+-2: alu=%h", alu_out);
        @(negedge clk);
        instruction = {6'h3F, 26'h3FFFFFF};
        #1;
        vectors++;
        if (dut_strobes() !== 9'd0 || branch_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL unknown_op strobes=%b want=000000000", dut_strobes());
        end
        $display("opcode 3F: strobes=%b", dut_strobes());
    endtask

    task automatic test_reset_vs_store();
        drive(K_SW, 32'd0, 32'h5555AAAA, 32'd12, 1'b0);
        @(posedge clk);
        drive(K_SW, 32'd0, 32'h1234, 32'd12, 1'b1);
        @(posedge clk);
        foreach (mem_model[i]) mem_model[i] = 32'd0;
        drive(K_LW, 32'd0, 32'h0, 32'd12, 1'b0);
        vectors++;
        if (WriteDataReg !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_vs_store got=%h want=%h", WriteDataReg, 32'd0);
        end
        $display("reset vs store idx3: wb=%h", WriteDataReg);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            kind_t       k;
            logic [31:0] a, b, imm, res, wb;
            logic        r;
            k   = kind_t'($urandom_range(0, 9));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = $urandom;
            r   = ($urandom_range(0, 39) == 0);
            drive(k, a, b, imm, r);
            res = result_of(k, a, b, imm);
            wb  = (k == K_LW) ? mem_model[res[7:2]] : res;
            vectors++;
            if (dut_strobes() !== strobes_of(k) || alu_out !== res || Zero !== (res == 0) ||
                branch_taken !== (k == K_BEQ && res == 0) || WriteDataReg !== wb) begin
                miscompares++;
                $display("FAIL rand_%0d kind=%0d strobes=%b/%b alu=%h/%h zero=%b bt=%b wb=%h/%h",
                         n, k, dut_strobes(), strobes_of(k), alu_out, res, Zero, branch_taken, WriteDataReg, wb);
            end
            $display("rand %0d kind=%0d rst=%b alu=%h wb=%h", n, k, r, alu_out, WriteDataReg);
            @(posedge clk);
            if (r) foreach (mem_model[i]) mem_model[i] = 32'd0;
            else if (k == K_SW) mem_model[res[7:2]] = b;
        end
    endtask

    initial begin
        rst = 1'b1;
        instruction = 32'd0;
        read_data1 = 32'd0;
        read_data2 = 32'd0;
        extend32 = 32'd0;
        test_reset();
        test_store_load();
        test_rtype();
        test_beq();
        test_addi_unknown();
        test_reset_vs_store();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
